timer_param: RTL and testbench
==============================

Name: timer_param

Overview:
- Parametrised countdown timer for the traffic-light controller; successor to the fixed 4-bit phase timer.
- Counts whole seconds using the shared one-cycle oneHz_enable strobe and flags expiry of each light phase to the controller FSM.
- Adds the following over the fixed timer:
  - configurable width;
  - hold (pause) for pedestrian/emergency override;
  - in-flight extension;
  - optional auto-reload for flashing modes;
  - visible remaining count for a display.

Parameters:
- WIDTH, 4, width of Value, extension amount and remaining count.
- AUTO_RELOAD_EN, 0, when 1 the auto_reload input is honoured; when 0 auto_reload is ignored (treated as 0).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- Reset_Sync  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- Value  input  WIDTH  phase duration in seconds, sampled when start_timer=1.
- oneHz_enable  input  1  one-clk-wide tick, once per second.
- start_timer  input  1  load Value and begin counting (level sampled each clk).
- hold  input  1  freeze countdown while 1.
- extend  input  1  add ext_Value to remaining count (one-clk pulse).
- ext_Value  input  WIDTH  extension amount in seconds.
- auto_reload  input  1  on expiry reload latched Value and keep running.
- expired  output  1  one-clk pulse on expiry (registered).
- busy  output  1  1 while in RUN or HOLD.
- time_remain  output  WIDTH  seconds remaining; 0 when idle.

Behaviour:
- Reset (Reset_Sync=0 at a rising edge) applies the following next cycle, overriding all other inputs including mid-count:
  - state=IDLE;
  - time_remain=0, reload register=0;
  - expired=0, busy=0.
- States:
  - IDLE: not counting.
  - RUN: decrement on tick.
  - HOLD: counting frozen.
- Start (highest priority after reset), when start_timer=1 at an edge in any state:
  - time_remain<=Value, reload register<=Value;
  - if Value=0: time_remain<=0 and expiry occurs on the next tick (as if Value=1);
  - state<=RUN, or HOLD if hold=1 at that edge;
  - a tick coincident with start is ignored, so the first decrement is on the next tick.
- RUN:
  - hold=1 → HOLD, and a tick in that same cycle is ignored.
  - Else on tick with time_remain>1: time_remain<=time_remain-1.
  - Else on tick with time_remain<=1: expired<=1 for exactly one cycle, then:
    - if auto_reload=1 and AUTO_RELOAD_EN=1: time_remain<=reload register, remain in RUN;
    - otherwise: time_remain<=0, state<=IDLE.
- HOLD:
  - Ticks ignored.
  - hold=0 → RUN next cycle; counting resumes from the held value on the next tick after returning to RUN.
- Latency: a tick on edge k produces the expired/time_remain update visible in cycle k+1. A V-second phase expires on the V-th tick after start.
- expired:
  - default 0 each cycle; never asserted in IDLE;
  - never asserted for two consecutive cycles.
- busy: registered, equals (state != IDLE).
- Extend (RUN or HOLD only; ignored in IDLE and when start_timer=1):
  - time_remain<=min(time_remain+ext_Value, 2^WIDTH-1), saturating;
  - compute the sum with one extra bit.
  - If extend and tick coincide in RUN: result = saturate(time_remain+ext_Value)-1 and no expiry that cycle, unless the result is ≤0 before decrement, i.e. both time_remain and ext_Value are 0.
  - Extension does not alter the reload register.
- Arithmetic: all unsigned WIDTH-bit; no wrap-around below 0; time_remain never decrements past 0.
- No internal initial values are relied upon; behaviour is defined only after the first reset.

Test Plan:
1. Reset low 2 clks, then Value=5, start pulse, 6 ticks 1000 clks apart:
   - time_remain 5→4→3→2→1;
   - expired pulses one clk after the 5th tick;
   - busy falls with it; 6th tick gives no pulse.
2. WIDTH=8, Value=200, start, 3 ticks, hold=1 for 5 ticks, release, then continue ticking:
   - time_remain holds 197 during hold;
   - expiry on total non-held tick 200.
3. Value=3, start, 1 tick (remain 2), extend with ext_Value=4:
   - remain 6; expiry after 6 further ticks.
   - Repeat with WIDTH=4, remain 14, ext_Value=5 → saturates 15.
4. AUTO_RELOAD_EN=1, auto_reload=1, Value=2, 7 ticks:
   - expired after ticks 2, 4, 6;
   - busy stays 1; time_remain 1 after tick 7.
5. Value=4, start, 2 ticks, then start with Value=9 coincident with a tick:
   - time_remain=9 (tick ignored); expiry 9 ticks later.
6. Mid-count (remain 3) assert Reset_Sync=0 together with tick and start:
   - next cycle time_remain=0, busy=0, expired=0.
   - Value=0 start: expiry on first tick.

Source files
------------

// File: rtl/timer_param_if.sv
// timer_param_if: groups the controller-facing signals of the phase timer.
//   master modport: the traffic-light controller (drives Value, oneHz_enable,
//                   start_timer, hold, extend, ext_Value, auto_reload;
//                   observes expired, busy, time_remain).
//   slave modport:  the timer itself.
// Handshake semantics: there is no valid/ready pair. start_timer and hold
// are levels sampled on every rising clk; oneHz_enable and extend are
// one-clk pulses acted on at the edge where they are high; expired is a
// registered one-clk pulse.
interface timer_param_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Value;
  logic             oneHz_enable;
  logic             start_timer;
  logic             hold;
  logic             extend;
  logic [WIDTH-1:0] ext_Value;
  logic             auto_reload;
  logic             expired;
  logic             busy;
  logic [WIDTH-1:0] time_remain;

  modport master (
    output Value, oneHz_enable, start_timer, hold, extend, ext_Value, auto_reload,
    input  expired, busy, time_remain
  );

  modport slave (
    input  Value, oneHz_enable, start_timer, hold, extend, ext_Value, auto_reload,
    output expired, busy, time_remain
  );
endinterface

// File: rtl/timer_param.sv
// timer_param: parametrised countdown timer for traffic-light phases.
// Counts whole seconds on the oneHz_enable strobe, pulses expired for one
// clk when a phase ends, supports hold, saturating extension, optional
// auto-reload and exposes the remaining count.
// Ports:
//   clk         rising-edge system clock
//   Reset_Sync  synchronous active-low reset
//   tif         timer_param_if.slave bundle (see interface header)
//   state_dbg   current FSM state (0=IDLE, 1=RUN, 2=HOLD) for observation
module timer_param #(
  parameter int WIDTH          = 4,
  parameter int AUTO_RELOAD_EN = 0
) (
  input  logic          clk,
  input  logic          Reset_Sync,
  timer_param_if.slave  tif,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;

  // Extension sum carries one extra bit so overflow is seen and clamped.
  logic [WIDTH:0]   ext_sum;
  logic [WIDTH-1:0] ext_sat;
  logic             reload_ok;

  assign ext_sum   = {1'b0, tif.time_remain} + {1'b0, tif.ext_Value};
  assign ext_sat   = ext_sum[WIDTH] ? {WIDTH{1'b1}} : ext_sum[WIDTH-1:0];
  assign reload_ok = (AUTO_RELOAD_EN != 0) && tif.auto_reload;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!Reset_Sync) begin
      state           <= IDLE;
      reload_q        <= '0;
      tif.time_remain <= '0;
      tif.expired     <= 1'b0;
      tif.busy        <= 1'b0;
    end else begin
      tif.expired <= 1'b0;
      if (tif.start_timer) begin
        // Value=0 loads 0; the next tick then takes the expiry path below.
        tif.time_remain <= tif.Value;
        reload_q        <= tif.Value;
        state           <= tif.hold ? HOLD : RUN;
        tif.busy        <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (tif.hold) begin
              // Entering HOLD: the tick is dropped but an extension still lands.
              state <= HOLD;
              if (tif.extend) tif.time_remain <= ext_sat;
            end else if (tif.oneHz_enable) begin
              // Expiry happens when the pre-decrement count (after any
              // extension) is at most 1; with an extension that only holds
              // when both operands are 0.
              if (tif.extend ? (ext_sat == '0) : (tif.time_remain <= WIDTH'(1))) begin
                tif.expired <= 1'b1;
                if (reload_ok) begin
                  tif.time_remain <= reload_q;
                end else begin
                  tif.time_remain <= '0;
                  state           <= IDLE;
                  tif.busy        <= 1'b0;
                end
              end else if (tif.extend) begin
                tif.time_remain <= ext_sat - WIDTH'(1);
              end else begin
                tif.time_remain <= tif.time_remain - WIDTH'(1);
              end
            end else if (tif.extend) begin
              tif.time_remain <= ext_sat;
            end
          end
          HOLD: begin
            if (tif.extend) tif.time_remain <= ext_sat;
            if (!tif.hold) state <= RUN;
          end
          default: begin
            state    <= IDLE;
            tif.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_param.sv
// tb_timer_param: directed bench for timer_param. Three instances share one
// stimulus set: u4 (WIDTH=4, no auto-reload), u8 (WIDTH=8, no auto-reload)
// and uar (WIDTH=4, auto-reload enabled). Ticks are spaced a few clks apart
// rather than a full second to keep the run short.
module tb_timer_param;

  localparam int GAP = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] value_r;
  logic [7:0] ext_r;
  logic       tick_r;
  logic       start_r;
  logic       hold_r;
  logic       extend_r;
  logic       auto_r;

  logic [1:0] st4, st8, star;

  int tests_run;
  int tests_failed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- interfaces + DUTs ----------------
  timer_param_if #(.WIDTH(4)) if4 ();
  timer_param_if #(.WIDTH(8)) if8 ();
  timer_param_if #(.WIDTH(4)) ifar ();

  assign if4.Value         = value_r[3:0];
  assign if4.ext_Value     = ext_r[3:0];
  assign if4.oneHz_enable  = tick_r;
  assign if4.start_timer   = start_r;
  assign if4.hold          = hold_r;
  assign if4.extend        = extend_r;
  assign if4.auto_reload   = auto_r;

  assign if8.Value         = value_r;
  assign if8.ext_Value     = ext_r;
  assign if8.oneHz_enable  = tick_r;
  assign if8.start_timer   = start_r;
  assign if8.hold          = hold_r;
  assign if8.extend        = extend_r;
  assign if8.auto_reload   = auto_r;

  assign ifar.Value        = value_r[3:0];
  assign ifar.ext_Value    = ext_r[3:0];
  assign ifar.oneHz_enable = tick_r;
  assign ifar.start_timer  = start_r;
  assign ifar.hold         = hold_r;
  assign ifar.extend       = extend_r;
  assign ifar.auto_reload  = auto_r;

  timer_param #(.WIDTH(4), .AUTO_RELOAD_EN(0)) u4 (
    .clk(clk), .Reset_Sync(rst_n), .tif(if4.slave), .state_dbg(st4)
  );
  timer_param #(.WIDTH(8), .AUTO_RELOAD_EN(0)) u8 (
    .clk(clk), .Reset_Sync(rst_n), .tif(if8.slave), .state_dbg(st8)
  );
  timer_param #(.WIDTH(4), .AUTO_RELOAD_EN(1)) uar (
    .clk(clk), .Reset_Sync(rst_n), .tif(ifar.slave), .state_dbg(star)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (always entered and left at a negedge) ----
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] v);
    value_r = v; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  // One tick; outputs are checked right after, then GAP idle clks follow
  // via gap().
  task automatic do_tick();
    tick_r = 1'b1;
    @(negedge clk);
    tick_r = 1'b0;
  endtask

  task automatic gap();
    cyc(GAP);
  endtask

  task automatic do_extend(input logic [7:0] e, input logic with_tick);
    ext_r = e; extend_r = 1'b1; tick_r = with_tick;
    @(negedge clk);
    extend_r = 1'b0; tick_r = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; value_r = '0; ext_r = '0; tick_r = 1'b0;
    start_r = 1'b0; hold_r = 1'b0; extend_r = 1'b0; auto_r = 1'b0;

    // 1: reset, then 5-second phase
    cyc(2);
    chk("rst_remain", if4.time_remain, 0);
    chk("rst_busy", if4.busy, 0);
    chk("rst_expired", if4.expired, 0);
    chk("rst_state", st4, 0);
    rst_n = 1'b1;
    cyc(1);
    do_start(8'd5);
    chk("t1_load", if4.time_remain, 5);
    chk("t1_busy", if4.busy, 1);
    chk("t1_state", st4, 1);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      if (i < 5) begin
        chk("t1_remain", if4.time_remain, 5 - i);
        chk("t1_noexp", if4.expired, 0);
      end else begin
        chk("t1_expired", if4.expired, 1);
        chk("t1_busy_fall", if4.busy, 0);
        chk("t1_zero", if4.time_remain, 0);
        chk("t1_idle", st4, 0);
      end
      cyc(1);
      chk("t1_exp_1clk", if4.expired, 0);
      gap();
    end
    do_tick();
    chk("t1_tick6_noexp", if4.expired, 0);
    chk("t1_tick6_busy", if4.busy, 0);
    gap();
    do_extend(8'd4, 1'b0);
    chk("idle_extend_ignored", if4.time_remain, 0);

    // 2: WIDTH=8 long phase with hold (first held cycle carries a tick)
    do_start(8'd200);
    chk("t2_load", if8.time_remain, 200);
    for (int i = 0; i < 3; i++) begin do_tick(); gap(); end
    chk("t2_after3", if8.time_remain, 197);
    hold_r = 1'b1;
    do_tick();
    chk("t2_hold_tick_ignored", if8.time_remain, 197);
    chk("t2_hold_state", st8, 2);
    for (int i = 0; i < 4; i++) begin gap(); do_tick(); end
    chk("t2_hold_frozen", if8.time_remain, 197);
    chk("t2_hold_busy", if8.busy, 1);
    hold_r = 1'b0;
    cyc(1);
    chk("t2_resume_state", st8, 1);
    chk("t2_resume_remain", if8.time_remain, 197);
    for (int i = 0; i < 196; i++) begin gap(); do_tick(); end
    chk("t2_tick199_remain", if8.time_remain, 1);
    chk("t2_tick199_noexp", if8.expired, 0);
    gap(); do_tick();
    chk("t2_tick200_exp", if8.expired, 1);
    chk("t2_tick200_busy", if8.busy, 0);
    gap();

    // 3: extension, saturation, extend+tick, extend in HOLD
    do_start(8'd3);
    do_tick();
    chk("t3_remain2", if4.time_remain, 2);
    do_extend(8'd4, 1'b0);
    chk("t3_ext6", if4.time_remain, 6);
    for (int i = 0; i < 5; i++) begin gap(); do_tick(); end
    chk("t3_remain1", if4.time_remain, 1);
    chk("t3_noexp", if4.expired, 0);
    gap(); do_tick();
    chk("t3_exp", if4.expired, 1);
    gap();
    do_start(8'd15);
    do_tick();
    chk("t3_remain14", if4.time_remain, 14);
    do_extend(8'd5, 1'b0);
    chk("t3_sat15", if4.time_remain, 15);
    chk("t3_w8_19", if8.time_remain, 19);
    do_extend(8'd2, 1'b1);
    chk("t3_sat_tick14", if4.time_remain, 14);
    chk("t3_sat_tick_noexp", if4.expired, 0);
    chk("t3_w8_ext_tick20", if8.time_remain, 20);
    hold_r = 1'b1;
    cyc(1);
    do_extend(8'd1, 1'b0);
    chk("t3_hold_ext15", if4.time_remain, 15);
    chk("t3_w8_hold_ext21", if8.time_remain, 21);
    hold_r = 1'b0;
    cyc(1);
    chk("t3_unhold_state", st4, 1);

    // 4: auto-reload (uar honours it, u4 ignores it)
    auto_r = 1'b1;
    do_start(8'd2);
    for (int i = 1; i <= 7; i++) begin
      do_tick();
      chk("t4_ar_expired", ifar.expired, (i % 2 == 0) ? 1 : 0);
      chk("t4_ar_remain", ifar.time_remain, (i % 2 == 0) ? 2 : 1);
      chk("t4_ar_busy", ifar.busy, 1);
      if (i == 2) begin
        chk("t4_noar_exp", if4.expired, 1);
        chk("t4_noar_busy", if4.busy, 0);
        chk("t4_noar_remain", if4.time_remain, 0);
      end
      gap();
    end
    auto_r = 1'b0;

    // 5: restart coincident with a tick
    do_start(8'd4);
    do_tick(); gap(); do_tick(); gap();
    chk("t5_remain2", if4.time_remain, 2);
    value_r = 8'd9; start_r = 1'b1; tick_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0; tick_r = 1'b0;
    chk("t5_restart9", if4.time_remain, 9);
    for (int i = 0; i < 8; i++) begin gap(); do_tick(); end
    chk("t5_remain1", if4.time_remain, 1);
    gap(); do_tick();
    chk("t5_exp", if4.expired, 1);
    gap();

    // 6: reset overrides start+tick mid-count; Value=0 phases
    do_start(8'd5);
    do_tick(); gap(); do_tick(); gap();
    chk("t6_remain3", if4.time_remain, 3);
    rst_n = 1'b0; tick_r = 1'b1; start_r = 1'b1; value_r = 8'd7;
    @(negedge clk);
    rst_n = 1'b1; tick_r = 1'b0; start_r = 1'b0;
    chk("t6_rst_remain", if4.time_remain, 0);
    chk("t6_rst_busy", if4.busy, 0);
    chk("t6_rst_expired", if4.expired, 0);
    do_start(8'd0);
    chk("t6_zero_load", if4.time_remain, 0);
    chk("t6_zero_busy", if4.busy, 1);
    do_tick();
    chk("t6_zero_exp", if4.expired, 1);
    chk("t6_zero_idle", if4.busy, 0);
    gap();
    do_start(8'd0);
    do_extend(8'd0, 1'b1);
    chk("t6_ext0_tick_exp", if4.expired, 1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
